tis_port_reader: RTL and testbench

//  Read side of the TIS-100 inter-node port protocol. One instance per node, between the four

---
 rtl/tis_port_reader_pkg.sv | 28 ++
 rtl/mux4_1.sv | 24 ++
 rtl/tis_port_reader_prio4.sv | 18 +
 rtl/tis_port_reader.sv | 136 +++++++++++++
 tb/tb_tis_port_reader.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tis_port_reader_pkg.sv
// Shared constants and types for the TIS-100 port read side.
package tis_port_reader_pkg;

  localparam int DATA_W_DEF = 8;

  // Read source codes as presented on rd_src; 7 decodes as NIL as well.
  localparam logic [2:0] SRC_UP    = 3'd0;
  localparam logic [2:0] SRC_RIGHT = 3'd1;
  localparam logic [2:0] SRC_DOWN  = 3'd2;
  localparam logic [2:0] SRC_LEFT  = 3'd3;
  localparam logic [2:0] SRC_ANY   = 3'd4;
  localparam logic [2:0] SRC_LAST  = 3'd5;
  localparam logic [2:0] SRC_NIL   = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } rd_state_t;

  // Resolved view of the latched source for the current cycle.
  typedef struct packed {
    logic [1:0] port;  // port to capture from / ack
    logic       hit;   // that port holds a word this cycle
    logic       zero;  // read completes with 0 and no handshake
  } src_res_t;

endpackage

// File: rtl/mux4_1.sv
// Plain 4:1 word mux.
module mux4_1 #(
  parameter int W = 8
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [W-1:0] y
);

  // select one of four words
  always_comb begin
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/tis_port_reader_prio4.sv
// Lowest-index pick over four port valids, used to resolve ANY reads.
module tis_port_prio4 (
  input  logic [3:0] valid,
  output logic [1:0] idx,
  output logic       hit
);

  // port 0 has highest priority; idx is 0 when nothing is valid
  always_comb begin
    hit = |valid;
    idx = 2'd0;
    if (valid[0])      idx = 2'd0;
    else if (valid[1]) idx = 2'd1;
    else if (valid[2]) idx = 2'd2;
    else if (valid[3]) idx = 2'd3;
  end

endmodule

// File: rtl/tis_port_reader.sv
// Node read port: resolves the read source, performs the valid/ack rendezvous
// with the neighbour writer, stalls the node meanwhile and registers the word.
module tis_port_reader
  import tis_port_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [2:0]        rd_src,
  input  logic [3:0]        wr_valid,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  output logic [3:0]        wr_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_done,
  output logic              rd_stall,
  output logic [1:0]        last_port
);

  rd_state_t         state, state_nxt;
  logic [2:0]        src_q;
  logic              last_vld;
  logic [1:0]        prio_idx;
  logic              prio_hit;
  src_res_t          res;
  logic [DATA_W-1:0] mux_y;
  logic              cap_port;
  logic              cap_zero;

  tis_port_prio4 u_prio (
    .valid (wr_valid),
    .idx   (prio_idx),
    .hit   (prio_hit)
  );

  mux4_1 #(.W(DATA_W)) u_mux (
    .sel (res.port),
    .d0  (in0),
    .d1  (in1),
    .d2  (in2),
    .d3  (in3),
    .y   (mux_y)
  );

  // resolve the latched source into a port, its valid, or a zero read
  always_comb begin
    res = '{port: src_q[1:0], hit: 1'b0, zero: 1'b0};
    case (src_q)
      SRC_UP, SRC_RIGHT, SRC_DOWN, SRC_LEFT: begin
        res.port = src_q[1:0];
        res.hit  = wr_valid[src_q[1:0]];
      end
      SRC_ANY: begin
        res.port = prio_idx;
        res.hit  = prio_hit;
      end
      SRC_LAST: begin
        if (last_vld) begin
          res.port = last_port;
          res.hit  = wr_valid[last_port];
        end else begin
          res.zero = 1'b1;
        end
      end
      default: res.zero = 1'b1;
    endcase
  end

  // next state, ack pulse and status; an abort wins over a present word
  always_comb begin
    state_nxt = state;
    wr_ack    = '0;
    cap_port  = 1'b0;
    cap_zero  = 1'b0;
    rd_done   = 1'b0;
    rd_stall  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rd_req) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        rd_stall = 1'b1;
        if (!rd_req) begin
          state_nxt = ST_IDLE;
        end else if (res.zero) begin
          cap_zero  = 1'b1;
          state_nxt = ST_DONE;
        end else if (res.hit) begin
          wr_ack[res.port] = 1'b1;
          cap_port         = 1'b1;
          state_nxt        = ST_DONE;
        end
      end
      ST_DONE: begin
        rd_done   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // source is latched at read start so later rd_src changes are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           src_q <= SRC_UP;
    else if (state == ST_IDLE && rd_req) src_q <= rd_src;
  end

  // word capture; held until the next completed read
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         rd_data <= '0;
    else if (cap_zero) rd_data <= '0;
    else if (cap_port) rd_data <= mux_y;
  end

  // remember which port won the most recent ANY, for LAST reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_port <= 2'd0;
      last_vld  <= 1'b0;
    end else if (cap_port && src_q == SRC_ANY) begin
      last_port <= res.port;
      last_vld  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tis_port_reader.sv
// Scoreboard bench for tis_port_reader: the driver plays node and four writers,
// predicts each read from the protocol rules, and a monitor checks DUT events.
module tb_tis_port_reader;
  import tis_port_reader_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rd_req = 1'b0;
  logic [2:0] rd_src = 3'd0;
  logic [3:0] wr_valid = 4'd0;
  logic [7:0] inw [4];
  logic [3:0] wr_ack;
  logic [7:0] rd_data;
  logic       rd_done, rd_stall;
  logic [1:0] last_port;

  tis_port_reader #(.DATA_W(8)) dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_src(rd_src),
    .wr_valid(wr_valid), .in0(inw[0]), .in1(inw[1]), .in2(inw[2]), .in3(inw[3]),
    .wr_ack(wr_ack), .rd_data(rd_data), .rd_done(rd_done), .rd_stall(rd_stall),
    .last_port(last_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] lp;
  } exp_done_t;

  logic [3:0] ackq [$];
  exp_done_t  doneq [$];
  int checks = 0;
  int errors = 0;

  // reference model: pending writer words and the LAST memory
  bit         pend [4];
  logic [7:0] word [4];
  bit         last_vld_m = 0;
  logic [1:0] last_port_m = 2'd0;

  logic [3:0] s_ack;
  bit         s_done, s_stall;

  // monitor: every ack / done the DUT presents must match the next prediction
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_ack != 4'd0) begin
        checks++;
        if (ackq.size() == 0) begin
          errors++;
          $display("FAIL stray_ack actual=%b required=none", wr_ack);
        end else begin
          logic [3:0] ea;
          ea = ackq.pop_front();
          if (wr_ack !== ea) begin
            errors++;
            $display("FAIL ack actual=%b required=%b", wr_ack, ea);
          end
        end
      end
      if (rd_done) begin
        checks++;
        if (doneq.size() == 0) begin
          errors++;
          $display("FAIL stray_done data=%h", rd_data);
        end else begin
          exp_done_t ed;
          ed = doneq.pop_front();
          if (rd_data !== ed.data || last_port !== ed.lp) begin
            errors++;
            $display("FAIL done actual data=%h last=%0d required data=%h last=%0d",
                     rd_data, last_port, ed.data, ed.lp);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // one cycle: sample at negedge, node drops rd_req on done, writers drop after ack
  task automatic tick();
    @(negedge clk);
    s_ack   = wr_ack;
    s_done  = rd_done;
    s_stall = rd_stall;
    if (s_done) rd_req = 1'b0;
    @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++)
      if (s_ack[n]) begin
        wr_valid[n] = 1'b0;
        pend[n]     = 1'b0;
      end
  endtask

  task automatic add_word(input int p, input logic [7:0] w);
    word[p]     = w;
    inw[p]      = w;
    wr_valid[p] = 1'b1;
    pend[p]     = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_ack",   int'(wr_ack), 0);
    chk("rst_stall", int'(rd_stall), 0);
    chk("rst_data",  int'(rd_data), 0);
    chk("rst_done",  int'(rd_done), 0);
    chk("rst_last",  int'(last_port), 0);
    rd_req = 1'b0;
    tick();
    tick();
    reset       = 1'b0;
    last_vld_m  = 0;
    last_port_m = 2'd0;
    ackq.delete();
    doneq.delete();
  endtask

  // one node read; d = cycles the target's word is late, ab = abort before it comes
  task automatic do_read(input logic [2:0] src, input int d_in, input bit ab_in, input int hold);
    int tgt, d, t, stalls;
    bit zero, late, ab, got;
    exp_done_t e;
    tgt = -1; zero = 0; late = 0;
    if (!src[2]) tgt = int'(src[1:0]);
    else if (src == SRC_ANY) begin
      for (int p = 3; p >= 0; p--) if (pend[p]) tgt = p;
      if (tgt < 0) tgt = int'($urandom_range(0, 3));
    end else if (src == SRC_LAST && last_vld_m) tgt = int'(last_port_m);
    else zero = 1;
    if (!zero) late = !pend[tgt];
    d  = late ? d_in : 0;
    ab = ab_in && late;
    if (late) word[tgt] = 8'($urandom);
    if (!ab) begin
      if (zero) begin
        e.data = 8'd0;
        e.lp   = last_port_m;
      end else begin
        if (src == SRC_ANY) begin
          last_port_m = 2'(tgt);
          last_vld_m  = 1;
        end
        ackq.push_back(4'b0001 << tgt);
        e.data = word[tgt];
        e.lp   = last_port_m;
      end
      doneq.push_back(e);
    end
    rd_src = src;
    rd_req = 1'b1;
    t = 0; got = 0; stalls = 0;
    while (!got && t < 40) begin
      tick();
      t++;
      if (s_stall) stalls++;
      if (s_done) got = 1;
      if (t == 1) rd_src = 3'($urandom);
      if (ab && t == hold) begin
        rd_req = 1'b0;
        break;
      end
      if (late && !ab && t == 1 + d) add_word(tgt, word[tgt]);
    end
    if (ab) begin
      tick();
      tick();
      chk("abort_idle", int'(rd_stall), 0);
      if (hold % 2 == 1) begin
        add_word(tgt, 8'($urandom));
        tick();
        tick();
        chk("abort_noack", int'(rd_stall), 0);
      end
    end else if (!got) begin
      errors++;
      $display("FAIL timeout src=%0d actual=no_done required=done", src);
      do_reset();
    end else begin
      chk("latency", t, 3 + d);
      chk("stall_cycles", stalls, 1 + d);
    end
  endtask

  initial begin
    for (int p = 0; p < 4; p++) begin
      inw[p] = 8'd0; word[p] = 8'd0; pend[p] = 0;
    end
    #3;
    do_reset();

    // single port already valid
    add_word(0, 8'h2A);
    do_read(SRC_UP, 0, 0, 1);
    chk("t2_data", int'(rd_data), 8'h2A);

    // reset mid-WAIT on port 2; the writer keeps its word
    rd_src = SRC_DOWN;
    rd_req = 1'b1;
    tick();
    tick();
    chk("t1_in_wait", int'(rd_stall), 1);
    reset = 1'b1;
    add_word(2, 8'h5C);
    do_reset();

    // LAST with no prior ANY, then NIL codes
    do_read(SRC_LAST, 1, 0, 1);
    do_read(SRC_NIL, 1, 0, 1);
    do_read(3'd7, 1, 0, 1);

    // late word on port 3
    inw[3] = 8'h00;
    do_read(SRC_LEFT, 4, 0, 1);

    // ANY with ports 1 and 2 valid, then LAST waits on port 1 only
    add_word(1, 8'h91);
    do_read(SRC_ANY, 0, 0, 1);
    chk("t4_last", int'(last_port), 1);
    chk("t4_p2_held", int'(wr_valid[2]), 1);
    do_read(SRC_LAST, 2, 0, 1);

    // abort, then the word arrives after the node gave up
    do_read(SRC_RIGHT, 2, 1, 3);

    for (int i = 0; i < 150; i++) begin
      for (int p = 0; p < 4; p++)
        if (!pend[p] && $urandom_range(0, 2) == 0) add_word(p, 8'($urandom));
      do_read(3'($urandom_range(0, 7)), int'($urandom_range(1, 4)),
              ($urandom_range(0, 7) == 0), int'($urandom_range(1, 3)));
      if ($urandom_range(0, 3) == 0) tick();
    end

    tick();
    tick();
    chk("queues_drained", ackq.size() + doneq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
